// File: rtl/genesis_pad_responder_if.sv
// genesis_pad_responder_if: pad-side signal bundle for the Genesis DB9 responder.
// master = host/reader side (drives select and button state), slave = the pad.
interface genesis_pad_responder_if;
    logic [7:0] buttons;   // {start, a, b, c, up, down, left, right}, pressed = 1
    logic [3:0] xyz_mode;  // {x, y, z, mode}, pressed = 1
    logic       sel;       // host select line, asynchronous to clk
    logic       pin0;      // DB9 pin 1, active-low
    logic       pin1;      // DB9 pin 2, active-low
    logic       pin2;      // DB9 pin 3, active-low
    logic       pin3;      // DB9 pin 4, active-low
    logic       pin5;      // DB9 pin 6, active-low
    logic       pin8;      // DB9 pin 9, active-low
    logic [2:0] phase;     // 6-button phase, 0..4

    modport master (
        output buttons, xyz_mode, sel,
        input  pin0, pin1, pin2, pin3, pin5, pin8, phase
    );

    modport slave (
        input  buttons, xyz_mode, sel,
        output pin0, pin1, pin2, pin3, pin5, pin8, phase
    );
endinterface

// File: rtl/genesis_pad_responder.sv
// genesis_pad_responder: device-side emulation of a Sega Genesis DB9 pad.
// Watches the host select line and drives the six multiplexed active-low pad
// lines from the button vectors, as a physical 3- or 6-button pad would.
// Optional feature macro: GENESIS_SIX_BUTTON_EN (6-button phase counter,
// idle timeout and extended mappings). Undefined: plain 3-button pad.
module genesis_pad_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 150000
) (
    input  logic                          clk,
    input  logic                          reset,
    genesis_pad_responder_if.slave        pad
);

    typedef enum logic [2:0] {
        PH0 = 3'd0,
        PH1 = 3'd1,
        PH2 = 3'd2,
        PH3 = 3'd3,
        PH4 = 3'd4
    } phase_t;

    // Named button views, all pressed = 1
    logic btn_start, btn_a, btn_b, btn_c;
    logic btn_up, btn_down, btn_left, btn_right;

    assign btn_start = pad.buttons[7];
    assign btn_a     = pad.buttons[6];
    assign btn_b     = pad.buttons[5];
    assign btn_c     = pad.buttons[4];
    assign btn_up    = pad.buttons[3];
    assign btn_down  = pad.buttons[2];
    assign btn_left  = pad.buttons[1];
    assign btn_right = pad.buttons[0];

    logic sel_meta;
    logic sel_s;

    // Pin register, ordered {pin0, pin1, pin2, pin3, pin5, pin8}
    logic [5:0] pins_q;
    logic [5:0] pins_d;

    // Two-flop synchronizer for the asynchronous select line; idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_meta <= 1'b1;
            sel_s    <= 1'b1;
        end else begin
            sel_meta <= pad.sel;
            sel_s    <= sel_meta;
        end
    end

`ifdef GENESIS_SIX_BUTTON_EN
    localparam int unsigned       IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    logic              sel_prev;
    logic              sel_fall;
    logic [IDLE_W-1:0] idle_q;
    logic [IDLE_W-1:0] idle_inc;
    logic              timeout;
    phase_t            phase_q;
    phase_t            phase_d;

    // Delayed copy of the synchronized select for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_prev <= 1'b1;
        end else begin
            sel_prev <= sel_s;
        end
    end

    assign sel_fall = sel_prev & ~sel_s;

    // Idle timer increment, saturating so it never wraps
    always_comb begin
        idle_inc = idle_q;
        if (idle_q != IDLE_MAX) begin
            idle_inc = idle_q + IDLE_W'(1);
        end
        timeout = (idle_inc == IDLE_MAX);
    end

    // Phase state and idle timer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PH0;
            idle_q  <= '0;
        end else begin
            phase_q <= phase_d;
            idle_q  <= sel_fall ? '0 : idle_inc;
        end
    end

    // Next phase: edges advance (saturating at 4), timeout returns to 0.
    // A timeout coinciding with an edge collapses to the first phase.
    always_comb begin
        phase_d = phase_q;
        if (sel_fall) begin
            if (timeout) begin
                phase_d = PH1;
            end else begin
                unique case (phase_q)
                    PH0:      phase_d = PH1;
                    PH1:      phase_d = PH2;
                    PH2:      phase_d = PH3;
                    PH3, PH4: phase_d = PH4;
                    default:  phase_d = PH0;
                endcase
            end
        end else if (timeout) begin
            phase_d = PH0;
        end
    end

    assign pad.phase = phase_q;
`else
    assign pad.phase = '0;
`endif

    // Pin mapping for the next output register value; uses the phase being
    // loaded in the same edge so the new mapping has no stale-phase cycle
    always_comb begin
        if (sel_s) begin
            pins_d = {~btn_up, ~btn_down, ~btn_left, ~btn_right, ~btn_b, ~btn_c};
        end else begin
            // pins 2/3 low while select is low: pad-present ID
            pins_d = {~btn_up, ~btn_down, 1'b0, 1'b0, ~btn_a, ~btn_start};
        end
`ifdef GENESIS_SIX_BUTTON_EN
        if (phase_d == PH3) begin
            if (sel_s) begin
                pins_d = {~pad.xyz_mode[1], ~pad.xyz_mode[2], ~pad.xyz_mode[3],
                          ~pad.xyz_mode[0], ~btn_b, ~btn_c};
            end else begin
                // all four low: 6-button ID
                pins_d = {4'b0000, ~btn_a, ~btn_start};
            end
        end else if ((phase_d == PH4) && !sel_s) begin
            pins_d = {4'b1111, ~btn_a, ~btn_start};
        end
`endif
    end

    // Registered active-low outputs; reset shows the idle select-high group
    always_ff @(posedge clk) begin
        if (reset) begin
            pins_q <= '1;
        end else begin
            pins_q <= pins_d;
        end
    end

    assign pad.pin0 = pins_q[5];
    assign pad.pin1 = pins_q[4];
    assign pad.pin2 = pins_q[3];
    assign pad.pin3 = pins_q[2];
    assign pad.pin5 = pins_q[1];
    assign pad.pin8 = pins_q[0];

endmodule

// File: tb/tb_genesis_pad_responder.sv
// tb_genesis_pad_responder: self-checking bench for genesis_pad_responder.
// Follows GENESIS_SIX_BUTTON_EN so the same bench covers both pad variants.
module tb_genesis_pad_responder;

    localparam int unsigned T = 100;
`ifdef GENESIS_SIX_BUTTON_EN
    localparam bit SIX = 1'b1;
`else
    localparam bit SIX = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    genesis_pad_responder_if pad ();

    genesis_pad_responder #(.TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .reset (reset),
        .pad   (pad)
    );

    always #5 clk = ~clk;

    logic [5:0] dut_pins;
    assign dut_pins = {pad.pin0, pad.pin1, pad.pin2, pad.pin3, pad.pin5, pad.pin8};

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Pad behaviour table: {pin0,pin1,pin2,pin3,pin5,pin8} from select level,
    // phase and pressed buttons.
    function automatic logic [5:0] pad_map(bit ss, int unsigned ph, logic [7:0] b, logic [3:0] m);
        if (ph == 3 && ss)  return ~{m[1], m[2], m[3], m[0], b[5], b[4]};
        if (ph == 3 && !ss) return {4'b0000, ~b[6], ~b[7]};
        if (ph == 4 && !ss) return {4'b1111, ~b[6], ~b[7]};
        if (ss)             return ~{b[3], b[2], b[1], b[0], b[5], b[4]};
        return {~b[3], ~b[2], 2'b00, ~b[6], ~b[7]};
    endfunction

    // Reference model: the pad sees select two edges late; a falling edge of
    // that view advances the phase; phase clears once T edges pass since the
    // last falling edge (or reset).
    int unsigned edge_no  = 0;
    int unsigned fall_ref = 0;
    int unsigned m_ph     = 0;
    bit          m_s1 = 1'b1, m_ss = 1'b1, m_ss_prev = 1'b1;
    logic [5:0]  m_pins = '1;
    logic [2:0]  m_phase = '0;

    always @(posedge clk) begin
        bit          fall;
        int unsigned age;
        edge_no++;
        if (reset) begin
            m_s1 = 1'b1; m_ss = 1'b1; m_ss_prev = 1'b1;
            m_ph = 0; fall_ref = edge_no; m_pins = '1;
        end else begin
            fall = m_ss_prev & ~m_ss;
            age  = edge_no - fall_ref;
            if (SIX) begin
                if (fall) begin
                    m_ph     = (age >= T) ? 1 : ((m_ph < 4) ? m_ph + 1 : 4);
                    fall_ref = edge_no;
                end else if (age >= T) begin
                    m_ph = 0;
                end
            end
            m_pins    = pad_map(m_ss, m_ph, pad.buttons, pad.xyz_mode);
            m_ss_prev = m_ss;
            m_ss      = m_s1;
            m_s1      = pad.sel;
        end
        m_phase = 3'(m_ph);
    end

    task automatic test_reset();
        pad.sel = 1'b0; pad.buttons = 8'hFF; pad.xyz_mode = 4'h0; reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (dut_pins !== 6'h3F) begin
                n_err++; $display("FAIL reset_pins got=%b want=%b", dut_pins, 6'h3F);
            end
            n_cmp++;
            if (pad.phase !== 3'd0) begin
                n_err++; $display("FAIL reset_phase got=%0d want=0", pad.phase);
            end
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (dut_pins !== 6'h00) begin
            n_err++; $display("FAIL reset_first_low got=%b want=%b", dut_pins, 6'h00);
        end
        n_cmp++;
        if (pad.phase !== (SIX ? 3'd1 : 3'd0)) begin
            n_err++; $display("FAIL reset_first_phase got=%0d want=%0d", pad.phase, SIX ? 1 : 0);
        end
    endtask

    task automatic test_three_button();
        pad.buttons = 8'b0010_1001;
        pad.sel = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 2) begin
                n_cmp++;
                if (dut_pins !== 6'b010011) begin
                    n_err++; $display("FAIL mux_hi_latency got=%b want=%b", dut_pins, 6'b010011);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (dut_pins !== 6'b011001) begin
                    n_err++; $display("FAIL mux_hi got=%b want=%b", dut_pins, 6'b011001);
                end
            end
            n_cmp++;
            if (dut_pins !== m_pins) begin
                n_err++; $display("FAIL mux_hi_model got=%b want=%b", dut_pins, m_pins);
            end
        end
        pad.sel = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 2) begin
                n_cmp++;
                if (dut_pins !== 6'b011001) begin
                    n_err++; $display("FAIL mux_lo_latency got=%b want=%b", dut_pins, 6'b011001);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (dut_pins !== 6'b010011) begin
                    n_err++; $display("FAIL mux_lo got=%b want=%b", dut_pins, 6'b010011);
                end
            end
            n_cmp++;
            if (dut_pins !== m_pins) begin
                n_err++; $display("FAIL mux_lo_model got=%b want=%b", dut_pins, m_pins);
            end
        end
    endtask

    task automatic test_six_button_burst();
        logic [7:0] b;
        logic [5:0] exp_lo, exp_hi, nrm_lo, nrm_hi;
        pad.sel = 1'b1; reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        b = 8'($urandom);
        pad.buttons = b; pad.xyz_mode = 4'b1001;
        repeat (6) @(negedge clk);
        nrm_lo = {~b[3], ~b[2], 2'b00, ~b[6], ~b[7]};
        nrm_hi = ~{b[3], b[2], b[1], b[0], b[5], b[4]};
        for (int i = 0; i < 4; i++) begin
            exp_lo = (SIX && i == 2) ? {4'b0000, ~b[6], ~b[7]} :
                     (SIX && i == 3) ? {4'b1111, ~b[6], ~b[7]} : nrm_lo;
            exp_hi = (SIX && i == 2) ? {4'b1100, ~b[5], ~b[4]} : nrm_hi;
            for (int half = 0; half < 2; half++) begin
                pad.sel = (half == 1);
                for (int c = 1; c <= 20; c++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (dut_pins !== m_pins) begin
                        n_err++; $display("FAIL burst_model edge=%0d got=%b want=%b", i, dut_pins, m_pins);
                    end
                    if (c == 10) begin
                        n_cmp++;
                        if (dut_pins !== (half == 0 ? exp_lo : exp_hi)) begin
                            n_err++; $display("FAIL burst_pins edge=%0d sel=%0d got=%b want=%b",
                                              i, half, dut_pins, half == 0 ? exp_lo : exp_hi);
                        end
                        n_cmp++;
                        if (pad.phase !== (SIX ? 3'(i + 1) : 3'd0)) begin
                            n_err++; $display("FAIL burst_phase edge=%0d got=%0d want=%0d",
                                              i, pad.phase, SIX ? i + 1 : 0);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_timeout();
        pad.sel = 1'b1;
        for (int c = 0; c < T + 20; c++) begin
            @(negedge clk);
            n_cmp++;
            if (pad.phase !== m_phase) begin
                n_err++; $display("FAIL timeout_phase cyc=%0d got=%0d want=%0d", c, pad.phase, m_phase);
            end
            n_cmp++;
            if (dut_pins !== m_pins) begin
                n_err++; $display("FAIL timeout_pins cyc=%0d got=%b want=%b", c, dut_pins, m_pins);
            end
        end
        n_cmp++;
        if (pad.phase !== 3'd0) begin
            n_err++; $display("FAIL timeout_cleared got=%0d want=0", pad.phase);
        end
        pad.sel = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pad.phase !== (SIX ? 3'd1 : 3'd0)) begin
            n_err++; $display("FAIL timeout_next_phase got=%0d want=%0d", pad.phase, SIX ? 1 : 0);
        end
        n_cmp++;
        if (dut_pins !== {~pad.buttons[3], ~pad.buttons[2], 2'b00, ~pad.buttons[6], ~pad.buttons[7]}) begin
            n_err++; $display("FAIL timeout_next_pins got=%b want=%b", dut_pins,
                              {~pad.buttons[3], ~pad.buttons[2], 2'b00, ~pad.buttons[6], ~pad.buttons[7]});
        end
    endtask

    task automatic test_edge_at_timeout();
        pad.sel = 1'b1; repeat (8) @(negedge clk);
        pad.sel = 1'b0; repeat (8) @(negedge clk);
        pad.sel = 1'b1; repeat (8) @(negedge clk);
        // reference falling edge: first low sample on the next rising edge
        pad.sel = 1'b0; repeat (10) @(negedge clk);
        pad.sel = 1'b1; repeat (T - 10) @(negedge clk);
        // this edge is detected exactly T edges after the reference one
        pad.sel = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pad.phase !== (SIX ? 3'd1 : 3'd0)) begin
            n_err++; $display("FAIL edge_timeout_phase got=%0d want=%0d", pad.phase, SIX ? 1 : 0);
        end
        n_cmp++;
        if (dut_pins !== m_pins) begin
            n_err++; $display("FAIL edge_timeout_pins got=%b want=%b", dut_pins, m_pins);
        end
        // idle count restarted: phase holds until T edges later, then clears
        for (int c = 0; c < T + 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (pad.phase !== m_phase) begin
                n_err++; $display("FAIL edge_timeout_idle cyc=%0d got=%0d want=%0d", c, pad.phase, m_phase);
            end
        end
        n_cmp++;
        if (pad.phase !== 3'd0) begin
            n_err++; $display("FAIL edge_timeout_clear got=%0d want=0", pad.phase);
        end
    endtask

    task automatic test_random();
        int unsigned hold = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_pins !== m_pins) begin
                n_err++; $display("FAIL rand_pins cyc=%0d got=%b want=%b", c, dut_pins, m_pins);
            end
            n_cmp++;
            if (pad.phase !== m_phase) begin
                n_err++; $display("FAIL rand_phase cyc=%0d got=%0d want=%0d", c, pad.phase, m_phase);
            end
            pad.buttons  = 8'($urandom);
            pad.xyz_mode = 4'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            if (hold == 0) begin
                pad.sel = ~pad.sel;
                hold = $urandom_range(1, ($urandom_range(0, 9) == 0) ? 130 : 25);
            end else begin
                hold--;
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_three_button();
        test_six_button_burst();
        test_timeout();
        test_edge_at_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/genesis_pad_responder.md
# genesis_pad_responder

Device-side responder for the Sega Genesis DB9 pad protocol: the other end of the select-driven pad reader in the controller path. It watches the host's select line and drives the six multiplexed, active-low pad lines from an internal button vector, exactly as a physical 3- or 6-button pad would. It lets the reader, the homescreen menu FSM and the VGA test screens run in simulation or in a loopback build without a real controller.

## Interface

- `TIMEOUT_CYCLES`, 150000, idle `clk` cycles without a select falling edge before the 6-button phase resets; 1.5 ms at 100 MHz.
- `clk` input 1: the single clock, 100 MHz system clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `buttons` input 8: pressed = 1. Bit order {start, a, b, c, up, down, left, right}, bit 7 to bit 0.
- `xyz_mode` input 4: pressed = 1. Bit order {x, y, z, mode}; used only with `SIX_BUTTON_EN`.
- `sel` input 1: host select line (DB9 pin 7, codebase `pin6`). Asynchronous to `clk`.
- `pin0`, `pin1`, `pin2`, `pin3` output 1 each: DB9 pins 1–4, active-low, registered.
- `pin5` output 1: DB9 pin 6, active-low, registered.
- `pin8` output 1: DB9 pin 9, active-low, registered.
- `phase` output 3: current 6-button phase, 0–4, for verification. Always 0 without `SIX_BUTTON_EN`.

## Operation

- `sel` passes through a 2-flop synchronizer (`sel_s`), then a one-cycle delayed copy. A falling edge is `prev & ~sel_s`.
- **Phase counter** (`SIX_BUTTON_EN` only), range 0..4:
  - Each falling edge increments `phase`, saturating at 4.
  - An idle counter clears to 0 on each falling edge, otherwise increments and saturates at `TIMEOUT_CYCLES`.
  - When the idle counter reaches `TIMEOUT_CYCLES`, `phase` returns to 0.
  - If the timeout and a falling edge occur in the same cycle, the edge wins: `phase` becomes 1 and the idle counter becomes 0.
- **Output mapping.** All pins are active-low, so pin = ~pressed. Outputs are listed {pin0, pin1, pin2, pin3, pin5, pin8}.
  - `sel_s`=1, normal: {~up, ~down, ~left, ~right, ~b, ~c}.
  - `sel_s`=0, normal: {~up, ~down, 0, 0, ~a, ~start}. Pins 2 and 3 are driven low; this is the pad-present ID.
  - `sel_s`=0, `phase`=3: {0, 0, 0, 0, ~a, ~start}. This is the 6-button ID.
  - `sel_s`=1, `phase`=3: {~z, ~y, ~x, ~mode, ~b, ~c}.
  - `sel_s`=0, `phase`=4: {1, 1, 1, 1, ~a, ~start}.
  - Every other combination uses the normal mapping.
- Button inputs are sampled into the output register every cycle with no debouncing. A button change appears on the pins 1 cycle later.
- **Reset.** `sel_s` and the delayed copy load 1. `phase` = 0, idle counter = 0. All six pins = 1 (select-high group, nothing pressed). Reset mid-burst abandons the burst; the next falling edge is treated as the first.

## Timing

- `sel` edge to pin update: 3 cycles (2 synchronizer stages plus the output register).
- `buttons` / `xyz_mode` to pin update: 1 cycle.
- The host must hold each select level for at least 4 cycles before sampling. At 100 MHz the reader's select period on `clk25` satisfies this.
- The phase update and the pin mapping using the new phase take effect in the same cycle as the output register update that follows the edge. No glitch cycle is permitted.
- The idle counter width is `$clog2(TIMEOUT_CYCLES+1)`. It never wraps.

## Configuration

- `GENESIS_SIX_BUTTON_EN` defined:
  - The phase counter, idle timer and extended mappings are compiled in.
  - The block behaves as a 6-button pad.
- `GENESIS_SIX_BUTTON_EN` undefined:
  - The counter and timer are removed.
  - `phase` is tied to 0 and `xyz_mode` is ignored.
  - Only the two normal mappings are used; the block behaves as a 3-button pad.

## Test plan

- **Reset.** Assert `reset` 2 cycles with `sel`=0 and `buttons`=8'hFF. Required: pins all 1 and `phase`=0 while in reset; first post-reset output with `sel`=0 is {0,0,0,0,0,0}, 3 cycles after release.
- **Three-button mux.** `buttons`=8'b0010_1001 (b, up, right). `sel`=1 gives {0,1,1,0,0,1}; `sel`=0 gives {0,1,0,0,1,1}, each 3 cycles after the `sel` change.
- **Six-button burst.** Toggle `sel` low/high every 20 cycles, 4 falling edges, `xyz_mode`=4'b1001 (x, mode).
  - Third low gives pins0-3 = 0000.
  - Third high gives pins0-3 = {1,1,0,0}, i.e. {~z, ~y, ~x, ~mode}.
  - Fourth low gives pins0-3 = 1111.
  - `phase` reads 1, 2, 3, 4.
- **Timeout.** After the burst, hold `sel`=1 for `TIMEOUT_CYCLES` (use 100 in sim). `phase`=0 exactly when the idle count reaches 100. The next falling edge gives `phase`=1 and the normal low mapping.
- **Edge at timeout.** Place a falling edge in the same cycle the idle count reaches `TIMEOUT_CYCLES`. Required: `phase`=1 and idle counter = 0.
- **Macro off.** Repeat the six-button burst with `GENESIS_SIX_BUTTON_EN` undefined. Required: `phase` stays 0 and every low period shows {~up, ~down, 0, 0, ~a, ~start}.
